if_fetch_stage: RTL and testbench

//   Instruction-fetch stage directly upstream of the ID pipeline register. Holds the PC,

---
 rtl/if_fetch_stage.sv | 130 +++++++++++++
 tb/tb_if_fetch_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage feeding the ID pipeline register.
// Holds the PC, issues one fetch at a time on a valid/ready request bus,
// buffers the returned word and presents {o_pc, o_inst} to ID.
// Redirects (interrupt over jump) retarget the PC and discard any fetch in flight.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   is_jump/jump_target      jump redirect from a later stage
//   is_intr/intr_target      interrupt redirect (priority over jump)
//   req_valid/req_ready      fetch request handshake, req_addr = current pc
//   resp_valid/resp_data     fetched instruction word
//   if_valid/if_ready_go     buffered instruction valid / stage done
//   id_allow_in              ID register can accept this cycle
//   o_pc/o_inst              presented instruction and its PC
module if_fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        is_jump,
    input  logic [63:0] jump_target,
    input  logic        is_intr,
    input  logic [63:0] intr_target,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [63:0] req_addr,
    input  logic        resp_valid,
    input  logic [31:0] resp_data,
    output logic        if_valid,
    output logic        if_ready_go,
    input  logic        id_allow_in,
    output logic [63:0] o_pc,
    output logic [31:0] o_inst
);

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [XLEN-1:0]   pc, pc_nxt;
    logic              drop, drop_nxt;
    logic [XLEN-1:0]   o_pc_nxt;
    logic [ILEN-1:0]   o_inst_nxt;
    logic              redirect;
    logic [XLEN-1:0]   target;

    assign redirect = is_intr | is_jump;
    assign target   = is_intr ? intr_target : jump_target;

    // Next-state, next-pc and response capture.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        drop_nxt   = drop;
        o_pc_nxt   = o_pc;
        o_inst_nxt = o_inst;
        unique case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (redirect) begin
                    pc_nxt = target;
                end
                if (req_ready) begin
                    state_nxt = WAIT;
                    // The accepted address is stale once a redirect lands with it.
                    if (redirect) begin
                        drop_nxt = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (redirect) begin
                    pc_nxt   = target;
                    drop_nxt = 1'b1;
                end else if (resp_valid) begin
                    if (drop) begin
                        drop_nxt  = 1'b0;
                        state_nxt = REQ;
                    end else begin
                        o_pc_nxt   = pc;
                        o_inst_nxt = resp_data;
                        state_nxt  = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_nxt    = target;
                    state_nxt = REQ;
                end else if (id_allow_in) begin
                    pc_nxt    = pc + XLEN'(PC_STEP);
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and registered outputs; handshake flags decode the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            drop      <= 1'b0;
            req_valid <= 1'b0;
            if_valid  <= 1'b0;
            o_pc      <= RESET_PC;
            o_inst    <= '0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            drop      <= drop_nxt;
            req_valid <= (state_nxt == REQ);
            if_valid  <= (state_nxt == HOLD);
            o_pc      <= o_pc_nxt;
            o_inst    <= o_inst_nxt;
        end
    end

    assign req_addr    = pc;
    assign if_ready_go = if_valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        is_jump, is_intr;
    logic [63:0] jump_target, intr_target;
    logic        req_valid, req_ready;
    logic [63:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        if_valid, if_ready_go, id_allow_in;
    logic [63:0] o_pc;
    logic [31:0] o_inst;

    if_fetch_stage dut (
        .clk(clk), .rst(rst),
        .is_jump(is_jump), .jump_target(jump_target),
        .is_intr(is_intr), .intr_target(intr_target),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .if_valid(if_valid), .if_ready_go(if_ready_go),
        .id_allow_in(id_allow_in), .o_pc(o_pc), .o_inst(o_inst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } xfer_t;

    xfer_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    xfer_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [63:0] pc, input logic [31:0] inst);
        xfer_t e;
        e.pc = pc;
        e.inst = inst;
        exp_q.push_back(e);
    endtask

    // Memory model: one-cycle response returning addr[31:0]; mem_stall holds it back.
    logic        mem_stall = 1'b0;
    logic        pend = 1'b0;
    logic [63:0] pend_addr = '0;
    always @(negedge clk) begin
        #1;
        resp_valid = 1'b0;
        resp_data  = 32'h0;
        if (pend && !mem_stall) begin
            resp_valid = 1'b1;
            resp_data  = pend_addr[31:0];
            pend       = 1'b0;
        end
        if (req_valid && req_ready) begin
            pend      = 1'b1;
            pend_addr = req_addr;
        end
    end

    // Monitor: every transfer to ID is checked against the scoreboard.
    always @(negedge clk) begin
        #2;
        if (rst && if_valid && id_allow_in && !is_jump && !is_intr) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_xfer: got pc %h inst %h expected none", o_pc, o_inst);
            end else begin
                xfer_t e;
                e = exp_q.pop_front();
                check("xfer_pc", o_pc, e.pc);
                check("xfer_inst", 64'(o_inst), 64'(e.inst));
                check("ready_go", 64'(if_ready_go), 64'(1'b1));
            end
        end
    end

    task automatic wait_req(input string name);
        for (int i = 0; i < 10; i++) begin
            if (req_valid) return;
            @(negedge clk);
        end
        check({name, "_req_timeout"}, 64'(req_valid), 64'(1'b1));
    endtask

    task automatic wait_ifv(input string name);
        for (int i = 0; i < 10; i++) begin
            if (if_valid) return;
            @(negedge clk);
        end
        check({name, "_ifv_timeout"}, 64'(if_valid), 64'(1'b1));
    endtask

    task automatic wait_xfer(input string name, input int n);
        for (int i = 0; i < 40; i++) begin
            if (xfer_cnt >= n) return;
            @(negedge clk);
        end
        check({name, "_xfer_timeout"}, 64'(xfer_cnt), 64'(n));
    endtask

    initial begin
        rst = 1'b0; is_jump = 1'b0; is_intr = 1'b0;
        jump_target = '0; intr_target = '0;
        req_ready = 1'b0; id_allow_in = 1'b0;
        resp_valid = 1'b0; resp_data = '0;

        // 1: reset values, then first request at RESET_PC
        repeat (3) begin
            @(negedge clk);
            check("rst_if_valid", 64'(if_valid), 64'(1'b0));
            check("rst_req_valid", 64'(req_valid), 64'(1'b0));
            check("rst_o_pc", o_pc, RST_PC);
            check("rst_o_inst", 64'(o_inst), 64'h0);
        end
        rst = 1'b1;
        @(negedge clk);
        wait_req("t1");
        check("t1_if_valid", 64'(if_valid), 64'(1'b0));
        check("t1_req_addr", req_addr, RST_PC);

        // 2: streaming fetch
        req_ready = 1'b1;
        id_allow_in = 1'b1;
        push(64'h8000_0000, 32'h8000_0000);
        push(64'h8000_0004, 32'h8000_0004);
        push(64'h8000_0008, 32'h8000_0008);
        push(64'h8000_000C, 32'h8000_000C);
        wait_xfer("t2", 4);

        // 3: backpressure in HOLD
        id_allow_in = 1'b0;
        wait_ifv("t3");
        repeat (5) begin
            check("t3_hold_pc", o_pc, 64'h8000_0010);
            check("t3_hold_inst", 64'(o_inst), 64'h8000_0010);
            check("t3_req_valid", 64'(req_valid), 64'(1'b0));
            @(negedge clk);
        end
        push(64'h8000_0010, 32'h8000_0010);
        id_allow_in = 1'b1;
        @(negedge clk);
        id_allow_in = 1'b0;
        mem_stall = 1'b1;
        check("t3_one_xfer", 64'(xfer_cnt), 64'd5);
        check("t3_req_valid_next", 64'(req_valid), 64'(1'b1));
        check("t3_req_addr_next", req_addr, 64'h8000_0014);

        // 4: jump while the response is pending
        @(negedge clk);
        check("t4_in_wait", 64'(req_valid), 64'(1'b0));
        is_jump = 1'b1;
        jump_target = 64'h8000_1000;
        @(negedge clk);
        is_jump = 1'b0;
        mem_stall = 1'b0;
        @(negedge clk);
        wait_req("t4");
        check("t4_req_addr", req_addr, 64'h8000_1000);
        push(64'h8000_1000, 32'h8000_1000);
        wait_ifv("t4");
        check("t4_o_pc", o_pc, 64'h8000_1000);
        id_allow_in = 1'b1;
        @(negedge clk);
        id_allow_in = 1'b0;

        // 5: interrupt and jump together in HOLD with id_allow_in
        wait_ifv("t5");
        check("t5_o_pc", o_pc, 64'h8000_1004);
        is_intr = 1'b1; intr_target = 64'h8000_2000;
        is_jump = 1'b1; jump_target = 64'h8000_3000;
        id_allow_in = 1'b1;
        @(negedge clk);
        is_intr = 1'b0; is_jump = 1'b0; id_allow_in = 1'b0;
        check("t5_xfer_cnt", 64'(xfer_cnt), 64'd6);
        check("t5_if_valid", 64'(if_valid), 64'(1'b0));
        check("t5_req_valid", 64'(req_valid), 64'(1'b1));
        check("t5_req_addr", req_addr, 64'h8000_2000);

        // 6: reset during WAIT with a response arriving
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("t6_if_valid", 64'(if_valid), 64'(1'b0));
        check("t6_req_valid", 64'(req_valid), 64'(1'b0));
        check("t6_o_pc", o_pc, RST_PC);
        check("t6_o_inst", 64'(o_inst), 64'h0);
        @(negedge clk);
        wait_req("t6");
        check("t6_req_addr", req_addr, RST_PC);

        // Redirect in REQ with req_ready, then PC wrap past 2^64
        is_jump = 1'b1;
        jump_target = 64'hFFFF_FFFF_FFFF_FFFC;
        id_allow_in = 1'b1;
        push(64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC);
        push(64'h0, 32'h0);
        @(negedge clk);
        is_jump = 1'b0;
        wait_xfer("t7", 8);
        id_allow_in = 1'b0;
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
